// File: rtl/fetch_pc_gen.sv
// Fetch-stage program counter: produces fetch-block addresses under valid/ready with redirect, stall and halt.
// Define FETCH_PC_GEN_EPOCH_EN to add the redirect epoch counter and its output port.
module fetch_pc_gen #(
   parameter int PC_WIDTH    = 32,
   parameter int INC_AMOUNT  = 4,
   parameter int FETCH_BYTES = 8,
   parameter int EPOCH_WIDTH = 2,
   localparam int CNT_WIDTH  = $clog2(FETCH_BYTES / INC_AMOUNT) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PC_WIDTH-1:0]   reset_vector,
   input  logic                  redirect_valid,
   input  logic [PC_WIDTH-1:0]   redirect_pc,
   input  logic                  stall,
   input  logic                  halt_req,
   output logic [PC_WIDTH-1:0]   pc_out,
   output logic                  pc_out_valid,
   input  logic                  pc_out_ready,
   output logic [CNT_WIDTH-1:0]  pc_out_cnt,
   output logic                  halted,
   output logic                  misalign
`ifdef FETCH_PC_GEN_EPOCH_EN
   ,
   output logic [EPOCH_WIDTH-1:0] epoch
`endif
);

   localparam int INC_BITS = $clog2(INC_AMOUNT);
   localparam logic [PC_WIDTH-1:0] INC_MASK   = ~(PC_WIDTH'(INC_AMOUNT - 1));
   localparam logic [PC_WIDTH-1:0] BLK_MASK   = ~(PC_WIDTH'(FETCH_BYTES - 1));
   localparam logic [PC_WIDTH-1:0] FETCH_STEP = PC_WIDTH'(FETCH_BYTES);

   if (INC_AMOUNT > FETCH_BYTES || EPOCH_WIDTH < 1) begin : g_param_check
      $error("fetch_pc_gen: invalid parameter combination");
   end

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t              state, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                misalign_d;
   logic                redirect_take;
   logic                accept;
   logic [PC_WIDTH-1:0] next_blk;
   logic [PC_WIDTH-1:0] blk_rem;

   assign pc_out       = pc_q;
   assign pc_out_valid = (state == RUN) && !stall;
   assign accept       = pc_out_valid && pc_out_ready;
   assign halted       = (state == HALTED);

   // Carry out of the top bit is dropped, so the last block wraps to address 0.
   assign next_blk   = (pc_q & BLK_MASK) + FETCH_STEP;
   assign blk_rem    = FETCH_STEP - (pc_q & ~BLK_MASK);
   assign pc_out_cnt = CNT_WIDTH'(blk_rem >> INC_BITS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= BOOT;
         pc_q     <= '0;
         misalign <= 1'b0;
      end else begin
         state    <= state_d;
         pc_q     <= pc_d;
         misalign <= misalign_d;
      end
   end

   // Redirect beats accept and halt; BOOT ignores everything but the reset vector.
   always_comb begin
      state_d       = state;
      pc_d          = pc_q;
      misalign_d    = 1'b0;
      redirect_take = 1'b0;
      case (state)
         BOOT: begin
            state_d = RUN;
            pc_d    = reset_vector & INC_MASK;
         end
         RUN: begin
            if (redirect_valid) begin
               redirect_take = 1'b1;
            end else begin
               if (accept) begin
                  pc_d = next_blk;
               end
               if (halt_req) begin
                  state_d = HALTED;
               end
            end
         end
         HALTED: begin
            if (redirect_valid) begin
               redirect_take = 1'b1;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
      if (redirect_take) begin
         state_d    = RUN;
         pc_d       = redirect_pc & INC_MASK;
         misalign_d = |(redirect_pc & ~INC_MASK);
      end
   end

`ifdef FETCH_PC_GEN_EPOCH_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         epoch <= '0;
      end else if (redirect_take) begin
         epoch <= epoch + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Randomized bench for fetch_pc_gen against a cycle-level behavioural model of the fetch PC.
// Epoch checks are included when FETCH_PC_GEN_EPOCH_EN is defined.
module tb_fetch_pc_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] reset_vector;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        halt_req;
   logic [31:0] pc_out;
   logic        pc_out_valid;
   logic        pc_out_ready;
   logic [1:0]  pc_out_cnt;
   logic        halted;
   logic        misalign;
`ifdef FETCH_PC_GEN_EPOCH_EN
   logic [1:0]  epoch;
`endif

   int checkCount = 0;
   int passCount  = 0;

   // Reference model state: mode 0 = booting, 1 = running, 2 = halted.
   int          mdl_mode;
   longint      mdl_pc;
   bit          mdl_mis;
   int          mdl_epoch;

   fetch_pc_gen #(
      .PC_WIDTH(32), .INC_AMOUNT(4), .FETCH_BYTES(8), .EPOCH_WIDTH(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .reset_vector(reset_vector),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .stall(stall),
      .halt_req(halt_req),
      .pc_out(pc_out),
      .pc_out_valid(pc_out_valid),
      .pc_out_ready(pc_out_ready),
      .pc_out_cnt(pc_out_cnt),
      .halted(halted),
      .misalign(misalign)
`ifdef FETCH_PC_GEN_EPOCH_EN
      ,
      .epoch(epoch)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll();
      checkOutput("pc_out", pc_out, 32'(mdl_pc));
      checkOutput("pc_out_valid", {31'd0, pc_out_valid}, {31'd0, (mdl_mode == 1) && !stall});
      checkOutput("pc_out_cnt", {30'd0, pc_out_cnt}, 32'((8 - (mdl_pc % 8)) / 4));
      checkOutput("halted", {31'd0, halted}, {31'd0, mdl_mode == 2});
      checkOutput("misalign", {31'd0, misalign}, {31'd0, mdl_mis});
`ifdef FETCH_PC_GEN_EPOCH_EN
      checkOutput("epoch", {30'd0, epoch}, 32'(mdl_epoch % 4));
`endif
   endtask

   // Called at a falling edge: check, drive, clock once, advance the model, return at the next falling edge.
   task automatic applyStimulus(input bit rv, input logic [31:0] ra, input bit st, input bit hr, input bit rdy);
      bit acc;
      redirect_valid = rv;
      redirect_pc    = ra;
      stall          = st;
      halt_req       = hr;
      pc_out_ready   = rdy;
      #1;
      checkAll();
      acc = (mdl_mode == 1) && !st && rdy;
      @(posedge clk);
      mdl_mis = 1'b0;
      if (mdl_mode == 0) begin
         mdl_mode = 1;
         mdl_pc   = (longint'(reset_vector) / 4) * 4;
      end else if (rv) begin
         mdl_mode = 1;
         mdl_pc   = (longint'(ra) / 4) * 4;
         mdl_mis  = (ra % 4) != 0;
         mdl_epoch++;
      end else if (mdl_mode == 1) begin
         if (acc) mdl_pc = ((mdl_pc / 8) + 1) * 8 % 64'h1_0000_0000;
         if (hr) mdl_mode = 2;
      end
      @(negedge clk);
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear before any clock edge.
   task automatic doReset(input logic [31:0] vec);
      #2 rst_n = 1'b0;
      #1;
      mdl_mode  = 0;
      mdl_pc    = 0;
      mdl_mis   = 1'b0;
      mdl_epoch = 0;
      stall     = 1'b0;
      checkAll();
      reset_vector = vec;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] randAddr();
      case ($urandom_range(0, 3))
         0:       randAddr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         1:       randAddr = 32'($urandom_range(0, 63));
         default: randAddr = $urandom;
      endcase
   endfunction

   initial begin
      rst_n          = 1'b0;
      reset_vector   = 32'h0000_1000;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      stall          = 1'b0;
      halt_req       = 1'b0;
      pc_out_ready   = 1'b1;
      mdl_mode  = 0;
      mdl_pc    = 0;
      mdl_mis   = 1'b0;
      mdl_epoch = 0;
      @(negedge clk);
      checkAll();
      rst_n = 1'b1;

      // Boot sequence and the documented corner cases.
      applyStimulus(1, 32'h0000_5000, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(1, 32'h0000_2004, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(1, 32'hFFFF_FFF8, 1, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 1, 0, 1);
      applyStimulus(1, 32'h0000_3002, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(1, 32'h0000_4000, 0, 1, 1);
      applyStimulus(0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 1);
      doReset(32'h0000_100E);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            doReset($urandom);
         end else begin
            applyStimulus($urandom_range(0, 99) < 15, randAddr(),
                          $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5,
                          $urandom_range(0, 99) < 70);
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
